// File: rtl/td4_run_ctrl.sv
// Program store and run-control sequencer for the TD4 4-bit CPU core.
// Optional breakpoint logic is enabled by defining TD4_BREAKPOINT_EN.
module td4_run_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic [3:0]       cpu_addr,
  output logic [7:0]       cpu_data,
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic [1:0]       state,
  output logic [3:0]       wptr
`ifdef TD4_BREAKPOINT_EN
  ,
  input  logic             brk_en,
  input  logic [3:0]       brk_addr,
  output logic             brk_hit
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_RUN  = 2'b01,
    OP_STEP = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  state_e           state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             rst_pulse_q, rst_pulse_d;
  logic [3:0]       wptr_q, wptr_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [7:0]       mem_q [16];
  logic             mem_we;
  logic             accept;
  logic             brk_trig;
`ifdef TD4_BREAKPOINT_EN
  logic             brk_hit_q, brk_hit_d;

  assign brk_trig = brk_en & (cpu_addr == brk_addr);
  assign brk_hit  = brk_hit_q;
`else
  assign brk_trig = 1'b0;
`endif

  assign cmd_ready = (state_q == S_IDLE) |
                     ((state_q == S_RUN) & (op_e'(cmd_op) == OP_HALT));
  assign accept    = cmd_valid & cmd_ready;
  assign cpu_data  = mem_q[cpu_addr];
  assign cpu_en    = cpu_en_q;
  assign cpu_rst   = cpu_rst_q;
  assign state     = state_q;
  assign wptr      = wptr_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    cpu_en_d    = 1'b0;
    cpu_rst_d   = cpu_rst_q;
    rst_pulse_d = 1'b0;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    per_d       = per_q;
    mem_we      = 1'b0;
`ifdef TD4_BREAKPOINT_EN
    brk_hit_d   = accept ? 1'b0 : brk_hit_q;
`endif
    // A HALT-issued reset lasts one cycle only.
    if (rst_pulse_q) cpu_rst_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_e'(cmd_op))
            OP_LOAD: begin
              mem_we = 1'b1;
              wptr_d = wptr_q + 4'd1;
            end
            OP_RUN: begin
              cpu_rst_d = 1'b0;
              cnt_d     = cmd_data[DIV_W-1:0];
              per_d     = cmd_data[DIV_W-1:0];
              state_d   = S_RUN;
            end
            OP_STEP: begin
              cpu_rst_d = 1'b0;
              state_d   = S_STEP;
            end
            OP_HALT: begin
              cpu_rst_d   = 1'b1;
              rst_pulse_d = 1'b1;
              wptr_d      = 4'd0;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Only HALT can be accepted here, and it beats a due pulse.
        if (accept) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          if (brk_trig) begin
            state_d = S_IDLE;
`ifdef TD4_BREAKPOINT_EN
            brk_hit_d = 1'b1;
`endif
          end else begin
            cpu_en_d = 1'b1;
            cnt_d    = per_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STEP: begin
        cpu_en_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cpu_en_q    <= 1'b0;
      cpu_rst_q   <= 1'b1;
      rst_pulse_q <= 1'b0;
      wptr_q      <= 4'd0;
      cnt_q       <= '0;
      per_q       <= '0;
`ifdef TD4_BREAKPOINT_EN
      brk_hit_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cpu_en_q    <= cpu_en_d;
      cpu_rst_q   <= cpu_rst_d;
      rst_pulse_q <= rst_pulse_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
`ifdef TD4_BREAKPOINT_EN
      brk_hit_q   <= brk_hit_d;
`endif
    end
  end

  // NOTE: the program store is cleared by reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[wptr_q] <= cmd_data;
    end
  end

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Directed self-checking bench for td4_run_ctrl with hand-computed expectations.
// Breakpoint checks are compiled in only when TD4_BREAKPOINT_EN is defined.
module tb_td4_run_ctrl;

  localparam logic [1:0] LOAD = 2'b00, RUN = 2'b01, STEP = 2'b10, HALT = 2'b11;

  logic       clk, rst_n, cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_en, cpu_rst;
  logic [1:0] state;
  logic [3:0] wptr;
`ifdef TD4_BREAKPOINT_EN
  logic       brk_en, brk_hit;
  logic [3:0] brk_addr;
`endif

  int n_vec = 0;
  int n_err = 0;

  td4_run_ctrl #(.DIV_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_en   (cpu_en),
    .cpu_rst  (cpu_rst),
    .state    (state),
    .wptr     (wptr)
`ifdef TD4_BREAKPOINT_EN
    ,
    .brk_en   (brk_en),
    .brk_addr (brk_addr),
    .brk_hit  (brk_hit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = LOAD; cmd_data = 8'h00; cpu_addr = 4'd0;
`ifdef TD4_BREAKPOINT_EN
    brk_en = 1'b0; brk_addr = 4'd0;
`endif
    #22;
    check("rst_state", state, 8'd0);
    check("rst_cpu_rst", cpu_rst, 8'd1);
    check("rst_cpu_en", cpu_en, 8'd0);
    check("rst_wptr", wptr, 8'd0);
    check("rst_mem0", cpu_data, 8'h00);
    check("rst_ready", cmd_ready, 8'd1);
    rst_n = 1'b1;
    tick();

    // Load three program bytes
    issue(LOAD, 8'hB3);
    issue(LOAD, 8'h52);
    issue(LOAD, 8'hF0);
    check("load_wptr", wptr, 8'd3);
    cpu_addr = 4'd1; #1;
    check("load_mem1", cpu_data, 8'h52);
    cpu_addr = 4'd2; #1;
    check("load_mem2", cpu_data, 8'hF0);
    check("load_cpu_rst", cpu_rst, 8'd1);
    check("load_cpu_en", cpu_en, 8'd0);

    // Single step
    issue(STEP, 8'h00);
    check("step_state", state, 8'd2);
    check("step_cpu_rst", cpu_rst, 8'd0);
    check("step_ready", cmd_ready, 8'd0);
    check("step_en0", cpu_en, 8'd0);
    tick();
    check("step_en1", cpu_en, 8'd1);
    check("step_idle", state, 8'd0);
    tick();
    check("step_en_fall", cpu_en, 8'd0);

    // Free run P=3 with ignored LOAD/STEP offered throughout
    issue(RUN, 8'd3);
    check("run3_state", state, 8'd1);
    check("run3_en0", cpu_en, 8'd0);
    cmd_valid = 1'b1; cmd_op = LOAD; cmd_data = 8'hAA; #1;
    check("run_ready_load", cmd_ready, 8'd0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("run3_en_e%0d", k), cpu_en, (k % 4 == 0) ? 8'd1 : 8'd0);
    end
    cmd_op = STEP; #1;
    check("run_ready_step", cmd_ready, 8'd0);
    cmd_valid = 1'b0; cmd_op = HALT; #1;
    check("run_ready_halt", cmd_ready, 8'd1);
    for (int k = 13; k <= 15; k++) begin
      tick();
      check($sformatf("run3_en_e%0d", k), cpu_en, 8'd0);
    end
    check("run3_still_run", state, 8'd1);
    check("run3_wptr_kept", wptr, 8'd3);
    cpu_addr = 4'd3; #1;
    check("run3_mem3_kept", cpu_data, 8'h00);
    issue(HALT, 8'h00);   // accepted on the cnt==0 edge
    check("halt_run_en", cpu_en, 8'd0);
    check("halt_run_state", state, 8'd0);
    check("halt_run_cpu_rst", cpu_rst, 8'd0);

    // HALT in IDLE: one-cycle cpu_rst, wptr cleared, memory kept
    issue(HALT, 8'h00);
    check("halt_idle_rst1", cpu_rst, 8'd1);
    check("halt_idle_wptr", wptr, 8'd0);
    tick();
    check("halt_idle_rst0", cpu_rst, 8'd0);
    tick();
    check("halt_idle_rst0b", cpu_rst, 8'd0);
    cpu_addr = 4'd0; #1;
    check("halt_mem0_kept", cpu_data, 8'hB3);

    // Free run P=0: enable every cycle
    issue(RUN, 8'd0);
    check("run0_en0", cpu_en, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("run0_en_e%0d", k), cpu_en, 8'd1);
    end
    issue(HALT, 8'h00);
    check("run0_halt_en", cpu_en, 8'd0);
    check("run0_halt_state", state, 8'd0);

    // 17 loads wrap the write pointer and overwrite word 0
    for (int i = 0; i <= 16; i++) issue(LOAD, 8'(i));
    check("wrap_wptr", wptr, 8'd1);
    cpu_addr = 4'd0; #1;
    check("wrap_mem0", cpu_data, 8'h10);
    cpu_addr = 4'd1; #1;
    check("wrap_mem1", cpu_data, 8'h01);
    cpu_addr = 4'd15; #1;
    check("wrap_mem15", cpu_data, 8'h0F);

    // Asynchronous reset in the middle of RUN
    issue(RUN, 8'd2);
    tick();
    #2 rst_n = 1'b0;
    #1;
    cpu_addr = 4'd0; #0;
    check("arst_state", state, 8'd0);
    check("arst_cpu_rst", cpu_rst, 8'd1);
    check("arst_wptr", wptr, 8'd0);
    check("arst_mem0", cpu_data, 8'h00);
    #1 rst_n = 1'b1;
    tick();

`ifdef TD4_BREAKPOINT_EN
    brk_en = 1'b1; brk_addr = 4'd5; cpu_addr = 4'd4;
    issue(RUN, 8'd0);
    tick();
    check("brk_pulse_at4", cpu_en, 8'd1);
    cpu_addr = 4'd5;
    tick();
    check("brk_no_pulse", cpu_en, 8'd0);
    check("brk_state", state, 8'd0);
    check("brk_hit1", brk_hit, 8'd1);
    tick();
    check("brk_hit_held", brk_hit, 8'd1);
    issue(LOAD, 8'h77);
    check("brk_hit_clr", brk_hit, 8'd0);
    brk_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
